// File: rtl/message_slicer_arbiter.sv
// rtl/message_slicer_arbiter.sv - round-robin arbiter feeding one message_slicer from N_REQ word holders
module message_slicer_arbiter #(
   parameter int N_REQ        = 4,
   parameter int LOG_N_REQ    = 2,
   parameter int N_SLICES     = 4,
   parameter int LOG_N_SLICES = 2,
   parameter int WIDTH        = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [N_REQ*WIDTH*N_SLICES-1:0]     in_data,
   input  logic [N_REQ-1:0]                    in_nd,
   output logic [N_REQ-1:0]                    in_ready,
   output logic [WIDTH*N_SLICES-1:0]           out_data,
   output logic                                out_nd,
   output logic [LOG_N_REQ-1:0]                out_src,
   output logic                                error
);

   localparam int MW = WIDTH * N_SLICES;

   logic [MW-1:0]           hold [N_REQ];
   logic [N_REQ-1:0]        full;
   logic [LOG_N_SLICES-1:0] cnt;
   logic [LOG_N_REQ-1:0]    last;
   logic                    grant;
   logic [LOG_N_REQ-1:0]    winner;

   function automatic logic [LOG_N_REQ-1:0] rr_idx(input logic [LOG_N_REQ-1:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= N_REQ) s = s - N_REQ;
      return LOG_N_REQ'(s);
   endfunction

   assign in_ready = ~full;

   // First full holder after the last winner, only when the slicer has drained.
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      if (cnt == '0) begin
         for (int i = 1; i <= N_REQ; i++) begin
            if (!grant && full[rr_idx(last, i)]) begin
               grant  = 1'b1;
               winner = rr_idx(last, i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full     <= '0;
         cnt      <= '0;
         last     <= LOG_N_REQ'(N_REQ - 1);
         out_data <= '0;
         out_nd   <= 1'b0;
         out_src  <= '0;
         error    <= 1'b0;
         for (int r = 0; r < N_REQ; r++) hold[r] <= '0;
      end else begin
         out_nd <= grant;
         if (grant) begin
            out_data <= hold[winner];
            out_src  <= winner;
            last     <= winner;
            cnt      <= LOG_N_SLICES'(N_SLICES - 1);
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         // A holder being granted this edge can accept a new word without overflow.
         for (int r = 0; r < N_REQ; r++) begin
            if (in_nd[r]) begin
               if (!full[r] || (grant && winner == LOG_N_REQ'(r))) begin
                  hold[r] <= in_data[r*MW +: MW];
                  full[r] <= 1'b1;
               end else begin
                  error <= 1'b1;
               end
            end else if (grant && winner == LOG_N_REQ'(r)) begin
               full[r] <= 1'b0;
            end
         end
      end
   end

endmodule
